// File: rtl/fir_seq_pkg.sv
// Shared definitions for the FIR sample sequencer slice.
// Holds default geometry, the sequencer state encodings and a
// popcount helper used to size in-flight filter traffic.
package fir_seq_pkg;

    localparam int N_DEF     = 16;
    localparam int DEPTH_DEF = 32;
    localparam int TAPS_DEF  = 4;

    // Sequencer states; encodings kept as plain constants for legacy tools.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLEAR = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_FLUSH = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    // Number of set bits in a (zero-extended) tag vector.
    function automatic logic [7:0] popcount16(input logic [15:0] v);
        logic [7:0] cnt;
        cnt = 8'd0;
        for (int i = 0; i < 16; i++) begin
            cnt = cnt + {7'd0, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/fir_out_fifo.sv
// Synchronous FIFO holding filtered samples until the consumer takes them.
// Ports: clk/reset (sync, active-high); push/push_data write side;
// pop/pop_data read side (pop_data is the current head); count, empty, full.
// A push while full is only honoured if a pop happens in the same cycle.
module fir_out_fifo #(
    parameter int N          = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic [N-1:0]                  push_data,
    input  logic                          pop,
    output logic [N-1:0]                  pop_data,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          empty,
    output logic                          full
);

    localparam int PW = $clog2(FIFO_DEPTH);

    logic [N-1:0]  mem_r [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW:0]   count_r;
    logic          do_push_s;
    logic          do_pop_s;

    assign empty    = (count_r == '0);
    assign full     = (count_r == (PW+1)'(FIFO_DEPTH));
    assign count    = count_r;
    assign pop_data = mem_r[rd_ptr_r];

    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);

    // Pointer and occupancy bookkeeping; pointers wrap on power-of-2 depth.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (PW+1)'(1);
                2'b01:   count_r <= count_r - (PW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

endmodule

// File: rtl/fir_sample_sequencer.sv
// Streams a sample buffer through an external moving-average filter, owns the
// filter reset, flushes its tail with zeros and returns results on a
// valid/ready stream. The filter cannot stall, so issue is credit-limited:
// a sample is only sent when the output FIFO is guaranteed room for it.
// Ports: clk/reset; cfg_we/cfg_addr/cfg_wdata buffer writes (idle only);
// start/stop/loop_en/burst_len run control; filt_rst/filt_data_in/
// filt_data_out filter interface; out_valid/out_ready/out_data result stream;
// busy, done (pulse) and cfg_err (sticky dropped-write flag) status.
module fir_sample_sequencer
    import fir_seq_pkg::*;
#(
    parameter int N          = N_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int AW         = $clog2(DEPTH),
    parameter int FILT_LAT   = 1,
    parameter int TAPS       = TAPS_DEF,
    parameter int CLR_CYC    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_addr,
    input  logic [N-1:0]  cfg_wdata,
    input  logic          start,
    input  logic          stop,
    input  logic          loop_en,
    input  logic [AW:0]   burst_len,
    output logic          filt_rst,
    output logic [N-1:0]  filt_data_in,
    input  logic [N-1:0]  filt_data_out,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_data,
    output logic          busy,
    output logic          done,
    output logic          cfg_err
);

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
    localparam int          CW      = $clog2(FIFO_DEPTH) + 1;

    logic [N-1:0]        sample_mem [DEPTH];

    logic [2:0]          state_r;
    logic [2:0]          state_nxt_s;
    logic [AW-1:0]       addr_r;
    logic [AW-1:0]       len_last_r;
    logic                loop_r;
    logic [7:0]          clr_cnt_r;
    logic [7:0]          flush_cnt_r;
    logic [N-1:0]        filt_data_in_r;
    logic                tag_in_r;
    logic [FILT_LAT-1:0] tag_sr_r;
    logic                busy_r;
    logic                done_r;
    logic                cfg_err_r;

    logic                start_ok_s;
    logic [AW:0]         eff_len_s;
    logic [7:0]          inflight_s;
    logic                credit_ok_s;
    logic                issue_s;
    logic [N-1:0]        issue_data_s;
    logic                fifo_push_s;
    logic                fifo_pop_s;
    logic [CW-1:0]       fifo_count_s;
    logic                fifo_empty_s;
    logic                fifo_full_s;

    assign filt_rst     = reset | (state_r == ST_CLEAR);
    assign filt_data_in = filt_data_in_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign cfg_err      = cfg_err_r;
    assign out_valid    = ~fifo_empty_s;

    assign start_ok_s = start & ~stop & (state_r == ST_IDLE);
    assign eff_len_s  = ((burst_len == '0) || (burst_len > DEPTH_L)) ? DEPTH_L : burst_len;

    // In-flight count includes the sample sitting on filt_data_in plus the
    // ones inside the filter pipeline; all of them will land in the FIFO.
    assign inflight_s  = popcount16(16'(tag_sr_r)) + {7'd0, tag_in_r};
    assign credit_ok_s = ~fifo_full_s &&
                         ((8'(fifo_count_s) + inflight_s + 8'd1) <= 8'(FIFO_DEPTH));

    // Filter output is valid for a tagged sample when its tag leaves the pipe.
    assign fifo_push_s = tag_sr_r[FILT_LAT-1];
    assign fifo_pop_s  = out_ready & ~fifo_empty_s;

    // Next-state and issue decision.
    always_comb begin
        state_nxt_s  = state_r;
        issue_s      = 1'b0;
        issue_data_s = '0;
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) begin
                    state_nxt_s = ST_CLEAR;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (clr_cnt_r == 8'(CLR_CYC - 1)) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_CLEAR;
                end
            end
            ST_RUN: begin
                issue_s      = credit_ok_s;
                issue_data_s = sample_mem[addr_r];
                // stop lets this cycle's issue complete, then flushes
                if (stop) begin
                    state_nxt_s = ST_FLUSH;
                end else if (credit_ok_s && (addr_r == len_last_r) && !loop_r) begin
                    state_nxt_s = ST_FLUSH;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_FLUSH: begin
                issue_s      = credit_ok_s;
                issue_data_s = '0;
                if (credit_ok_s && (flush_cnt_r == 8'(TAPS - 1))) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_FLUSH;
                end
            end
            ST_DRAIN: begin
                if (inflight_s == 8'd0) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Sequencer state, counters, filter drive and status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            addr_r         <= '0;
            len_last_r     <= '0;
            loop_r         <= 1'b0;
            clr_cnt_r      <= 8'd0;
            flush_cnt_r    <= 8'd0;
            filt_data_in_r <= '0;
            tag_in_r       <= 1'b0;
            tag_sr_r       <= '0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            cfg_err_r      <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            busy_r   <= (state_nxt_s != ST_IDLE);
            done_r   <= (state_nxt_s == ST_DONE);
            tag_in_r <= issue_s;
            tag_sr_r <= (tag_sr_r << 1) | FILT_LAT'(tag_in_r);

            // On a stall the filter input simply repeats the last value.
            if (issue_s) begin
                filt_data_in_r <= issue_data_s;
            end else if (start_ok_s || (state_r == ST_CLEAR)) begin
                filt_data_in_r <= '0;
            end else begin
                filt_data_in_r <= filt_data_in_r;
            end

            if (start_ok_s) begin
                addr_r     <= '0;
                len_last_r <= AW'(eff_len_s - (AW+1)'(1));
                loop_r     <= loop_en;
            end else if ((state_r == ST_RUN) && issue_s) begin
                if (addr_r == len_last_r) begin
                    addr_r <= '0;
                end else begin
                    addr_r <= addr_r + AW'(1);
                end
            end else begin
                addr_r <= addr_r;
            end

            if (start_ok_s) begin
                clr_cnt_r <= 8'd0;
            end else if (state_r == ST_CLEAR) begin
                clr_cnt_r <= clr_cnt_r + 8'd1;
            end else begin
                clr_cnt_r <= clr_cnt_r;
            end

            if (state_r == ST_RUN) begin
                flush_cnt_r <= 8'd0;
            end else if ((state_r == ST_FLUSH) && issue_s) begin
                flush_cnt_r <= flush_cnt_r + 8'd1;
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end

            if (start_ok_s) begin
                cfg_err_r <= 1'b0;
            end else if (cfg_we && busy_r) begin
                cfg_err_r <= 1'b1;
            end else begin
                cfg_err_r <= cfg_err_r;
            end
        end
    end

    // Sample buffer write port; contents survive reset by design.
    always_ff @(posedge clk) begin
        if (cfg_we && !busy_r) begin
            sample_mem[cfg_addr] <= cfg_wdata;
        end
    end

    fir_out_fifo #(
        .N          (N),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push_s),
        .push_data (filt_data_out),
        .pop       (fifo_pop_s),
        .pop_data  (out_data),
        .count     (fifo_count_s),
        .empty     (fifo_empty_s),
        .full      (fifo_full_s)
    );

endmodule

// File: tb/tb_fir_sample_sequencer.sv
// Directed bench for fir_sample_sequencer with a behavioural 4-tap
// moving-average filter (1-cycle latency) attached to the filter port.
module tb_fir_sample_sequencer;

    localparam int N  = 16;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          cfg_we;
    logic [AW-1:0] cfg_addr;
    logic [N-1:0]  cfg_wdata;
    logic          start;
    logic          stop;
    logic          loop_en;
    logic [AW:0]   burst_len;
    logic          filt_rst;
    logic [N-1:0]  filt_data_in;
    logic [N-1:0]  filt_data_out;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_data;
    logic          busy;
    logic          done;
    logic          cfg_err;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt;
    int rst_cyc;
    logic signed [31:0] got_q[$];
    int exp_q[$];
    int buf_model[32];

    always #5 clk = ~clk;

    fir_sample_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .cfg_we        (cfg_we),
        .cfg_addr      (cfg_addr),
        .cfg_wdata     (cfg_wdata),
        .start         (start),
        .stop          (stop),
        .loop_en       (loop_en),
        .burst_len     (burst_len),
        .filt_rst      (filt_rst),
        .filt_data_in  (filt_data_in),
        .filt_data_out (filt_data_out),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .busy          (busy),
        .done          (done),
        .cfg_err       (cfg_err)
    );

    // Behavioural moving-average filter: out = (x[n]+x[n-1]+x[n-2]+x[n-3]) >>> 2
    logic signed [N-1:0] h0, h1, h2;
    logic signed [N+1:0] fsum;
    assign fsum = $signed(filt_data_in) + h0 + h1 + h2;

    always @(posedge clk) begin
        if (filt_rst) begin
            h0 <= '0;
            h1 <= '0;
            h2 <= '0;
            filt_data_out <= '0;
        end else begin
            h0 <= $signed(filt_data_in);
            h1 <= h0;
            h2 <= h1;
            filt_data_out <= N'(fsum >>> 2);
        end
    end

    // Output monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && out_ready) got_q.push_back(32'($signed(out_data)));
            if (done) done_cnt++;
            if (filt_rst) rst_cyc++;
        end
    end

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int d);
        cfg_we    = 1'b1;
        cfg_addr  = AW'(a);
        cfg_wdata = N'(d);
        tick();
        cfg_we    = 1'b0;
    endtask

    task automatic kick(input int len, input logic lp);
        got_q.delete();
        done_cnt  = 0;
        rst_cyc   = 0;
        burst_len = (AW+1)'(len);
        loop_en   = lp;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    // Wait for done and for the FIFO to empty, bounded.
    task automatic finish_run(input string tag);
        int cyc;
        cyc = 0;
        while ((done_cnt == 0 || busy || out_valid) && cyc < 3000) begin
            tick();
            cyc++;
        end
        chk({tag, "_timeout"}, 32'(cyc < 3000), 32'sd1);
        tick();
    endtask

    // Reference: 4-tap average over the issued input sequence.
    task automatic calc_exp(input int xs[$]);
        int s;
        exp_q.delete();
        for (int k = 0; k < xs.size(); k++) begin
            s = 0;
            for (int j = 0; j < 4; j++) begin
                if (k - j >= 0) s += xs[k-j];
            end
            exp_q.push_back(s >>> 2);
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk($sformatf("%s[%0d]", tag, i), got_q[i], 32'(exp_q[i]));
        end
    endtask

    initial begin
        int xs[$];
        int t1_exp[12] = '{0, 2, 7, 15, 25, 35, 45, 55, 45, 32, 17, 0};
        int k;
        int cyc;

        reset = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        start = 1'b0; stop = 1'b0; loop_en = 1'b0; burst_len = '0; out_ready = 1'b1;
        done_cnt = 0; rst_cyc = 0;
        repeat (3) tick();
        chk("rst_busy",      32'(busy),      32'sd0);
        chk("rst_done",      32'(done),      32'sd0);
        chk("rst_cfg_err",   32'(cfg_err),   32'sd0);
        chk("rst_out_valid", 32'(out_valid), 32'sd0);
        chk("rst_filt_rst",  32'(filt_rst),  32'sd1);
        chk("rst_filt_din",  32'(filt_data_in), 32'sd0);
        reset = 1'b0;
        tick();
        chk("idle_filt_rst", 32'(filt_rst), 32'sd0);

        // Test 1: ramp buffer, len 8
        for (int i = 0; i < 32; i++) wr(i, i * 10);
        kick(8, 1'b0);
        finish_run("t1");
        chk("t1_count", 32'(got_q.size()), 32'sd12);
        for (int i = 0; i < 12 && i < got_q.size(); i++)
            chk($sformatf("t1_out[%0d]", i), got_q[i], 32'(t1_exp[i]));
        chk("t1_filt_rst_cycles", 32'(rst_cyc), 32'sd2);
        chk("t1_done_pulses", 32'(done_cnt), 32'sd1);
        chk("t1_busy_after", 32'(busy), 32'sd0);

        // Test 2: impulse, len 32, then len 0 and len 40 (both mean 32)
        for (int i = 0; i < 32; i++) wr(i, (i == 0) ? 100 : 0);
        xs.delete();
        xs.push_back(100);
        for (int i = 1; i < 36; i++) xs.push_back(0);
        calc_exp(xs);
        kick(32, 1'b0);
        finish_run("t2");
        compare_all("t2");
        kick(0, 1'b0);
        finish_run("t2_len0");
        chk("t2_len0_count", 32'(got_q.size()), 32'sd36);
        kick(40, 1'b0);
        finish_run("t2_len40");
        chk("t2_len40_count", 32'(got_q.size()), 32'sd36);

        // start together with stop is ignored
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        tick();
        chk("start_stop_ignored", 32'(busy), 32'sd0);

        // Tests 3+5: looping run with a dropped write, then stop
        buf_model[0] = 4; buf_model[1] = 8; buf_model[2] = 12; buf_model[3] = 16;
        for (int i = 0; i < 4; i++) wr(i, buf_model[i]);
        kick(4, 1'b1);
        repeat (8) tick();
        wr(0, 777);
        chk("t5_cfg_err_set", 32'(cfg_err), 32'sd1);
        repeat (17) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        finish_run("t3");
        k = got_q.size() - 4;
        chk("t3_issues_ge20", 32'(k >= 20), 32'sd1);
        xs.delete();
        for (int i = 0; i < k; i++) xs.push_back(buf_model[i % 4]);
        for (int i = 0; i < 4; i++) xs.push_back(0);
        calc_exp(xs);
        compare_all("t3");
        chk("t3_last_zero", got_q[got_q.size()-1], 32'sd0);
        chk("t3_done_pulses", 32'(done_cnt), 32'sd1);
        chk("t5_cfg_err_sticky", 32'(cfg_err), 32'sd1);

        // Test 4: backpressure mid-run on a constant buffer
        for (int i = 0; i < 32; i++) wr(i, 40);
        kick(32, 1'b0);
        chk("t5_cfg_err_cleared", 32'(cfg_err), 32'sd0);
        cyc = 0;
        while (got_q.size() < 6 && cyc < 200) begin
            tick();
            cyc++;
        end
        chk("t4_reach6", 32'(cyc < 200), 32'sd1);
        out_ready = 1'b0;
        repeat (50) tick();
        chk("t4_stalled_busy",  32'(busy),      32'sd1);
        chk("t4_stalled_valid", 32'(out_valid), 32'sd1);
        chk("t4_no_done",       32'(done_cnt),  32'sd0);
        out_ready = 1'b1;
        finish_run("t4");
        xs.delete();
        for (int i = 0; i < 32; i++) xs.push_back(40);
        for (int i = 0; i < 4; i++) xs.push_back(0);
        calc_exp(xs);
        compare_all("t4");

        // Test 6: reset in RUN cycle 5
        kick(32, 1'b0);
        repeat (7) tick();
        chk("t6_busy_before", 32'(busy), 32'sd1);
        reset = 1'b1;
        tick();
        chk("t6_busy",      32'(busy),      32'sd0);
        chk("t6_out_valid", 32'(out_valid), 32'sd0);
        chk("t6_filt_rst",  32'(filt_rst),  32'sd1);
        reset = 1'b0;
        tick();
        chk("t6_filt_rst_rel", 32'(filt_rst),  32'sd0);
        chk("t6_busy_rel",     32'(busy),      32'sd0);
        chk("t6_valid_rel",    32'(out_valid), 32'sd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
